// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: 64-bit arctangent table, rotation gain, FSM state type and
// rounding helpers for the cordic math blocks.
package cordic_pkg;

  typedef enum logic [1:0] {IDLE, ITER, DONE} cordic_state_t;

  typedef logic [63:0][63:0] atan_table_t;

  // pi scaled by 2^124
  localparam logic [127:0] PI_Q124 = 128'h3243F6A8885A308D313198A2E0370734;

  // K * 2^63, K = 0.6072529350088812
  localparam logic [63:0] CORDIC_GAIN_64 = 64'd5600919740058905300;

  // atan(2^-i)/pi * 2^63, evaluated via the arctan power series at 2^124 scale
  function automatic logic [63:0] atan_entry(input int unsigned i);
    logic [191:0] acc;
    logic [191:0] term;
    logic [191:0] num;
    logic [191:0] pi_w;
    if (i == 0) return 64'h2000_0000_0000_0000;
    acc = '0;
    for (int unsigned k = 0; k < 40; k++) begin
      term = (192'(1) << 124) >> (i * (2 * k + 1));
      term = term / 192'(2 * k + 1);
      if (k[0]) acc = acc - term;
      else      acc = acc + term;
    end
    pi_w = 192'(PI_Q124);
    num  = (acc << 63) + (pi_w >> 1);
    return 64'(num / pi_w);
  endfunction

  function automatic atan_table_t gen_atan_table();
    atan_table_t t;
    for (int unsigned i = 0; i < 64; i++) t[i] = atan_entry(i);
    return t;
  endfunction

  localparam atan_table_t ATAN_TABLE = gen_atan_table();

  function automatic logic [63:0] round_shr64(input logic [63:0] v, input int unsigned s);
    if (s == 0) return v;
    return (v + (64'(1) << (s - 1))) >> s;
  endfunction

endpackage

// File: rtl/cordic_rotate_step.sv
// One combinational CORDIC micro-rotation in rotation mode; direction follows the sign of z.
module cordic_rotate_step #(
  parameter int DW = 36,
  parameter int ZW = 34,
  parameter int IW = 6
) (
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic        [IW-1:0] i,
  input  logic        [ZW-1:0] atan_i,
  output logic signed [DW-1:0] x_next,
  output logic signed [DW-1:0] y_next,
  output logic signed [ZW-1:0] z_next
);

  logic signed [DW-1:0] x_shr;
  logic signed [DW-1:0] y_shr;

  always_comb begin
    x_shr = x >>> i;
    y_shr = y >>> i;
    if (!z[ZW-1]) begin
      x_next = x - y_shr;
      y_next = y + x_shr;
      z_next = z - $signed(atan_i);
    end else begin
      x_next = x + y_shr;
      y_next = y - x_shr;
      z_next = z + $signed(atan_i);
    end
  end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC sine/cosine engine with quadrant folding and start/done handshake.
// Define CORDIC_SINCOS_SATURATE_EN to clamp outputs to exactly +/-1.0.
module cordic_sincos #(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 30,
  parameter int GUARD      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] angle,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sin_value,
  output logic [WIDTH-1:0] cos_value
);

  import cordic_pkg::*;

  localparam int ZW = WIDTH + GUARD;
  localparam int DW = ZW + 2;
  localparam int CW = 6;
  localparam int unsigned ATAN_SHIFT = 64 - ZW;
  localparam int unsigned GAIN_SHIFT = 65 - ZW;
  localparam logic signed [DW-1:0] X_INIT =
    DW'(round_shr64(CORDIC_GAIN_64, GAIN_SHIFT));
  localparam logic signed [DW-1:0] ROUND_HALF =
    (GUARD == 0) ? '0 : (DW'(1) << (GUARD - 1));
  localparam logic signed [DW-1:0] POS_ONE = DW'(1) << (WIDTH - 2);
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS);

  cordic_state_t state;
  cordic_state_t next_state;

  logic [CW-1:0]        count;
  logic signed [DW-1:0] x;
  logic signed [DW-1:0] y;
  logic signed [ZW-1:0] z;
  logic                 negate;

  logic                 fold;
  logic [WIDTH-1:0]     angle_fold;
  logic signed [ZW-1:0] z0;
  logic [ZW-1:0]        atan_i;
  logic signed [DW-1:0] x_next;
  logic signed [DW-1:0] y_next;
  logic signed [ZW-1:0] z_next;

  // |angle| >= pi/2 is rotated by pi into the convergent half-plane and negated afterwards
  assign fold       = angle[WIDTH-1] ^ angle[WIDTH-2];
  assign angle_fold = fold ? {~angle[WIDTH-1], angle[WIDTH-2:0]} : angle;
  assign z0         = ZW'(angle_fold) << GUARD;
  assign atan_i     = ZW'(round_shr64(ATAN_TABLE[count], ATAN_SHIFT));

  cordic_rotate_step #(.DW(DW), .ZW(ZW), .IW(CW)) u_step (
    .x      (x),
    .y      (y),
    .z      (z),
    .i      (count),
    .atan_i (atan_i),
    .x_next (x_next),
    .y_next (y_next),
    .z_next (z_next)
  );

  function automatic logic [WIDTH-1:0] out_fmt(input logic signed [DW-1:0] v, input logic neg);
    logic signed [DW-1:0] r;
    r = (v + ROUND_HALF) >>> GUARD;
    if (neg) r = -r;
`ifdef CORDIC_SINCOS_SATURATE_EN
    if (r > POS_ONE)       r = POS_ONE;
    else if (r < -POS_ONE) r = -POS_ONE;
`endif
    return WIDTH'(r);
  endfunction

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) next_state = ITER;
      end
      ITER: if (count == LAST) next_state = DONE;
      DONE: begin
        done = 1'b1;
        if (!start) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // count == ITERATIONS is a write-back cycle so done lands ITERATIONS+1 edges after start
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      negate    <= 1'b0;
      sin_value <= '0;
      cos_value <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (start) begin
          x      <= X_INIT;
          y      <= '0;
          z      <= z0;
          negate <= fold;
          count  <= '0;
        end
        ITER: if (count != LAST) begin
          x     <= x_next;
          y     <= y_next;
          z     <= z_next;
          count <= count + 1'b1;
        end else begin
          sin_value <= out_fmt(y, negate);
          cos_value <= out_fmt(x, negate);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos: table vectors, handshake/reset sequences and
// random angles against a real-arithmetic sin/cos model.
module tb_cordic_sincos;

  localparam int W   = 32;
  localparam int TOL = 64;
  localparam real PI = 3.14159265358979323846;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] angle;
  logic         ready;
  logic         done;
  logic [W-1:0] sin_value;
  logic [W-1:0] cos_value;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cordic_sincos #(.WIDTH(W), .ITERATIONS(30), .GUARD(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .angle     (angle),
    .ready     (ready),
    .done      (done),
    .sin_value (sin_value),
    .cos_value (cos_value)
  );

  typedef struct {
    logic [31:0] angle;
    int          exp_sin;
    int          exp_cos;
  } vec_t;

  vec_t vecs[6];

  task automatic check_near(input string name, input longint act, input longint exp);
    longint diff;
    diff = act - exp;
    n_vec++;
    if (diff > TOL || diff < -TOL) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, TOL);
    end
  endtask

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int to_fixed(input real r);
    real s;
    s = r * 1073741824.0;
    if (s >= 0.0) return $rtoi(s + 0.5);
    return -$rtoi(-s + 0.5);
  endfunction

  function automatic real to_rad(input logic [31:0] a);
    return $itor($signed(a)) * PI / 2147483648.0;
  endfunction

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) check_eq("ready_timeout", 0, 1);
  endtask

  // Launches one request, scrambles angle while busy, returns latency and results.
  task automatic run_req(input logic [31:0] a, output int lat, output int s, output int c);
    wait_ready();
    angle = a;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    angle = $urandom;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
      angle = $urandom;
    end
    if (!done) check_eq("done_timeout", 0, 1);
    s = $signed(sin_value);
    c = $signed(cos_value);
  endtask

  initial begin
    int lat, s, c, s0, c0, unstable, guard;
    logic [31:0] a;

    vecs[0] = '{32'd0,          0,          1073741824};
    vecs[1] = '{32'd536870912,  759250125,  759250125};
    vecs[2] = '{32'd1073741824, 1073741824, 0};
    vecs[3] = '{32'h80000000,   0,          -1073741824};
    vecs[4] = '{32'd1431655765, 929887697,  -536870912};
    vecs[5] = '{32'hAAAAAAAB,   -929887697, -536870912};

    reset = 1'b1;
    start = 1'b0;
    angle = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ready", ready, 1);
    check_eq("reset_done", done, 0);
    check_eq("reset_sin", sin_value, 0);
    check_eq("reset_cos", cos_value, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i].angle, lat, s, c);
      check_eq($sformatf("latency[%0d]", i), lat, 31);
      check_near($sformatf("sin[%0d]", i), s, vecs[i].exp_sin);
      check_near($sformatf("cos[%0d]", i), c, vecs[i].exp_cos);
    end

    // start held high through done: DONE must persist with stable outputs
    wait_ready();
    angle = 32'd536870912;
    start = 1'b1;
    guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("hold_reached_done", done, 1);
    s0 = $signed(sin_value);
    c0 = $signed(cos_value);
    check_near("hold_sin", s0, 759250125);
    unstable = 0;
    repeat (10) begin
      @(negedge clk);
      if (!done || $signed(sin_value) != s0 || $signed(cos_value) != c0) unstable++;
    end
    check_eq("hold_stable_cycles", unstable, 0);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("drop_done", done, 0);
    check_eq("drop_ready", ready, 1);
    check_eq("idle_hold_sin", $signed(sin_value), s0);

    // reset in the middle of the iterations aborts the request
    wait_ready();
    angle = 32'd1073741824;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_eq("pre_abort_busy", ready, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_ready", ready, 1);
    check_eq("abort_done", done, 0);
    check_eq("abort_sin", sin_value, 0);
    check_eq("abort_cos", cos_value, 0);
    @(negedge clk);
    reset = 1'b0;
    run_req(32'd1431655765, lat, s, c);
    check_eq("post_abort_latency", lat, 31);
    check_near("post_abort_sin", s, 929887697);
    check_near("post_abort_cos", c, -536870912);

`ifdef CORDIC_SINCOS_SATURATE_EN
    run_req(32'd1073741824, lat, s, c);
    check_eq("sat_sin_le_one", (s <= 1073741824) ? 1 : 0, 1);
    check_eq("sat_cos_ge_neg_one", (c >= -1073741824) ? 1 : 0, 1);
`endif

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      run_req(a, lat, s, c);
      check_near($sformatf("rnd_sin a=%0d", $signed(a)), s, to_fixed($sin(to_rad(a))));
      check_near($sformatf("rnd_cos a=%0d", $signed(a)), c, to_fixed($cos(to_rad(a))));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_sincos.md
Name: cordic_sincos

Overview:
Iterative, parametrised CORDIC rotation engine that computes sine and cosine of a full-circle binary angle in one request.
- Successor to the single-output sine block. Adds: parametrised width and iteration count, full ±pi angle range via quadrant folding, simultaneous sin/cos outputs, and a start/done hold handshake.
- Sits behind the same request-style control as the other cordic blocks in the math datapath.

Parameters:
WIDTH, 32, bit width of angle and outputs; legal 16..48.
ITERATIONS, 30, micro-rotations per request; legal 8..WIDTH-2.
GUARD, 2, extra LSBs carried internally on x/y/z datapath; legal 0..4.

Ports:
clk  input  1  rising-edge clock; single clock domain.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only while ready=1.
angle  input  WIDTH  signed binary angle; 2^(WIDTH-1) LSB = pi, so full range [-pi, pi).
ready  output  1  high only in IDLE.
done  output  1  high while results are valid (DONE state).
sin_value  output  WIDTH  signed, 1.0 = 2^(WIDTH-2).
cos_value  output  WIDTH  signed, 1.0 = 2^(WIDTH-2).

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, ready=1, done=0, sin_value=0, cos_value=0, iteration counter=0.
  - Reset asserted mid-operation aborts the request; the state is IDLE on the next edge.
- States: IDLE, ITER, DONE.
- IDLE: if start=1 at a rising edge, the engine captures angle and enters ITER with counter=0; ready drops.
  - Angle changes after capture are ignored.
- Quadrant fold at capture:
  - If angle[WIDTH-1] != angle[WIDTH-2] (|angle| >= pi/2), z0 = angle with its MSB inverted (angle+pi) and the negate flag is set.
  - Otherwise z0 = angle and the flag is clear.
  - x0 = K * 2^(WIDTH-2+GUARD), where K = 0.6072529350088812; y0 = 0.
- ITER: one micro-rotation per cycle, i = counter.
  - d = +1 if z>=0, else -1.
  - x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan_i.
  - Shifts are arithmetic.
  - atan_i = ATAN_TABLE[i] (64-bit angle units) >> (64-WIDTH-GUARD), rounded to nearest.
  - After the iteration with counter = ITERATIONS-1, the next edge enters DONE.
- Output write on entering DONE:
  - sin_value = y, cos_value = x, each rounded to nearest and reduced from WIDTH+GUARD to WIDTH bits.
  - Both are negated if the negate flag is set.
- Latency: done rises on the (ITERATIONS+1)th rising edge after the edge that sampled start.
- DONE: done=1; outputs are held stable.
  - The state remains DONE while start=1.
  - The first edge with start=0 returns to IDLE, where done=0 and ready=1.
  - Outputs hold their last value in IDLE.
- Back-to-back requests: minimum one IDLE cycle between requests.
  - A start already high on re-entry to IDLE is accepted at the next edge.
- Internal x/y are WIDTH+GUARD+2 bits to absorb CORDIC gain growth; z is WIDTH+GUARD bits with wrap-around arithmetic.

Optional Feature:
CORDIC_SINCOS_SATURATE_EN
- Defined: after rounding and negation, each output is clamped to [-2^(WIDTH-2), +2^(WIDTH-2)], i.e. exactly ±1.0.
- Undefined: the raw rounded result is output and may exceed ±1.0 by a few LSB.
- Latency is identical in both builds.

Decomposition:
- Package cordic_pkg holds:
  - ATAN_TABLE: 64 entries × 64 bits, atan(2^-i)/pi * 2^63.
  - CORDIC_GAIN_64: K * 2^63.
  - typedef enum cordic_state_t {IDLE, ITER, DONE}.
  - Rounding/shift helper functions.
- One sub-module, cordic_rotate_step: combinational single micro-rotation (x, y, z, i, atan_i in; x', y', z' out), parametrised on datapath width.

Test Plan:
All cases use WIDTH=32, ITERATIONS=30, tolerance ±64 LSB.
- angle=0 -> sin≈0, cos≈1073741824; done rises exactly 31 edges after the start-sample edge.
- angle=536870912 (pi/4) -> sin≈cos≈759250125.
- angle=1073741824 (pi/2, fold boundary) -> sin≈1073741824, cos≈0. angle=32'h80000000 (-pi) -> sin≈0, cos≈-1073741824.
- angle=1431655765 (2pi/3) -> sin≈929887697, cos≈-536870912. angle=-1431655765 -> sin≈-929887697, cos≈-536870912.
- Handshake:
  - Start held high 10 cycles past done: done stays 1 and outputs stay stable.
  - Start dropped: done=0 and ready=1 one edge later.
  - Angle toggled during ITER does not change the result.
- Reset asserted at iteration 12 -> next edge: ready=1, done=0, outputs=0; a new request then completes correctly.
- Saturation build: angle=1073741824 -> sin_value <= 1073741824.
